// File: rtl/nios_system_nios2_mul_seq_if.sv
// Request/response bundle of the shared multiply sequencer: two requester
// ports with valid/ready handshakes and a shared 64-bit result bus.
interface nios_system_nios2_mul_seq_if;
  logic        req_valid_0, req_ready_0;
  logic [31:0] req_a_0, req_b_0;
  logic [1:0]  req_sign_0;
  logic        req_valid_1, req_ready_1;
  logic [31:0] req_a_1, req_b_1;
  logic [1:0]  req_sign_1;
  logic        rsp_valid_0, rsp_ready_0;
  logic        rsp_valid_1, rsp_ready_1;
  logic [63:0] rsp_data;
  logic        busy;

  modport slave (
    input  req_valid_0, req_a_0, req_b_0, req_sign_0,
    input  req_valid_1, req_a_1, req_b_1, req_sign_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, busy
  );

  modport master (
    output req_valid_0, req_a_0, req_b_0, req_sign_0,
    output req_valid_1, req_a_1, req_b_1, req_sign_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data, busy
  );
endinterface

// File: rtl/nios_system_nios2_mul_seq.sv
// Shared 32x32->64 multiply sequencer: one pipelined 16x16 unsigned multiplier,
// four partial products per request, signed correction applied at the end.
module nios_system_nios2_mul_seq #(
  parameter int MUL_LATENCY = 1,
  parameter bit RR_EN       = 1'b1
) (
  input logic clk,
  input logic reset,
  nios_system_nios2_mul_seq_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] FIX   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [1:0] DRAIN_LAST = 2'(MUL_LATENCY - 1);

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic        owner, last_served;
  logic [31:0] op_a, op_b;
  logic [1:0]  op_sign;
  logic [63:0] acc, rsp_q;

  logic        grant0, grant1, accept, rsp_take;
  logic [15:0] mul_a, mul_b;
  logic [1:0]  mul_sh;
  logic        issue_vld;
  logic [63:0] prod_ext, corr_a, corr_b;

  // Multiplier pipeline: product, shift tag (units of 16 bits) and valid.
  logic [MUL_LATENCY:1] vld_pipe;
  logic [31:0]          prod_pipe [1:MUL_LATENCY];
  logic [1:0]           sh_pipe   [1:MUL_LATENCY];

  // Tie goes to the port not served last; fixed priority favours port 0.
  assign grant0 = bus.req_valid_0 & (~bus.req_valid_1 | ~RR_EN | last_served);
  assign grant1 = bus.req_valid_1 & ~grant0;
  assign accept = (state == IDLE) & (grant0 | grant1);

  // cnt[0] picks the A half, cnt[1] the B half; shift = 16*(cnt[0]+cnt[1]).
  assign issue_vld = (state == ISSUE);
  assign mul_a     = cnt[0] ? op_a[31:16] : op_a[15:0];
  assign mul_b     = cnt[1] ? op_b[31:16] : op_b[15:0];
  assign mul_sh    = {cnt[1] & cnt[0], cnt[1] ^ cnt[0]};

  assign prod_ext = {32'b0, prod_pipe[MUL_LATENCY]} << {sh_pipe[MUL_LATENCY], 4'b0};
  assign corr_a   = (op_sign[0] & op_a[31]) ? {op_b, 32'b0} : 64'b0;
  assign corr_b   = (op_sign[1] & op_b[31]) ? {op_a, 32'b0} : 64'b0;
  assign rsp_take = owner ? bus.rsp_ready_1 : bus.rsp_ready_0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        prod_pipe[k] <= '0;
        sh_pipe[k]   <= '0;
      end
    end else begin
      vld_pipe[1]  <= issue_vld;
      prod_pipe[1] <= mul_a * mul_b;
      sh_pipe[1]   <= mul_sh;
      for (int k = 2; k <= MUL_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        prod_pipe[k] <= prod_pipe[k-1];
        sh_pipe[k]   <= sh_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      op_a        <= '0;
      op_b        <= '0;
      op_sign     <= '0;
      acc         <= '0;
      rsp_q       <= '0;
    end else begin
      if (vld_pipe[MUL_LATENCY]) acc <= acc + prod_ext;
      case (state)
        IDLE: if (accept) begin
          owner       <= grant1;
          last_served <= grant1;
          op_a        <= grant1 ? bus.req_a_1    : bus.req_a_0;
          op_b        <= grant1 ? bus.req_b_1    : bus.req_b_0;
          op_sign     <= grant1 ? bus.req_sign_1 : bus.req_sign_0;
          acc         <= '0;
          cnt         <= '0;
          state       <= ISSUE;
        end
        ISSUE: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DRAIN;
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        FIX: begin
          rsp_q <= acc - corr_a - corr_b;
          state <= DONE;
        end
        DONE: if (rsp_take) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_0 = ~reset & accept & grant0;
  assign bus.req_ready_1 = ~reset & accept & grant1;
  assign bus.rsp_valid_0 = (state == DONE) & ~owner;
  assign bus.rsp_valid_1 = (state == DONE) & owner;
  assign bus.rsp_data    = rsp_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: doc/nios_system_nios2_mul_seq.md
Name: nios_system_nios2_mul_seq

Overview:
Shared multi-cycle 32x32->64 multiply sequencer. It time-multiplexes one pipelined 16x16 unsigned multiplier (registered product, same structure as the Nios II multiply cell) between two requesters: the CPU's extended multiply path and a custom-instruction port. It arbitrates, issues four partial products, accumulates them, applies signed correction and returns the 64-bit result over a valid/ready handshake.

Parameters:
MUL_LATENCY, 1, pipeline depth in cycles of the internal 16x16 multiplier (operands in -> product out); legal 1..3
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req_valid_0  in  1  port 0 request valid
req_ready_0  out  1  port 0 request accepted this cycle
req_a_0  in  32  port 0 operand A
req_b_0  in  32  port 0 operand B
req_sign_0  in  2  port 0 signedness: [0] A signed, [1] B signed
req_valid_1  in  1  port 1 request valid
req_ready_1  out  1  port 1 request accepted this cycle
req_a_1  in  32  port 1 operand A
req_b_1  in  32  port 1 operand B
req_sign_1  in  2  port 1 signedness, as port 0
rsp_valid_0  out  1  result for port 0 valid
rsp_ready_0  in  1  port 0 takes result
rsp_valid_1  out  1  result for port 1 valid
rsp_ready_1  in  1  port 1 takes result
rsp_data  out  64  product (shared by both ports)
busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; rsp_valid_0/1=0; rsp_data=0; busy=0; accumulator, captured operands and multiplier pipeline valid bits cleared; last_served=1 so port 0 wins first contention.
- States: IDLE -> ISSUE (4 cycles, idx 0..3) -> DRAIN (MUL_LATENCY cycles) -> FIX (1 cycle) -> DONE -> IDLE.
- IDLE: grant computed combinationally. Single valid -> that port. Both valid: RR_EN=1 -> port != last_served; RR_EN=0 -> port 0. req_ready_x = (state==IDLE) & grant_x. Handshake cycle = "cycle 0": operands, sign bits and owner captured; last_served<=owner; acc<=0; go ISSUE. req_ready_* = 0 in every other state.
- Operands are captured; requester changes after cycle 0 are ignored.
- ISSUE idx (cycles 1..4): multiplier inputs idx0 A[15:0]xB[15:0], idx1 A[31:16]xB[15:0], idx2 A[15:0]xB[31:16], idx3 A[31:16]xB[31:16]; a tagged shift (0, 16, 16, 32) travels with the product through the pipeline.
- Product of idx i emerges in cycle 1+i+MUL_LATENCY; acc <= acc + (product << shift), modulo 2^64. DRAIN continues until the last product is accumulated.
- FIX (cycle 5+MUL_LATENCY): rsp_data <= acc - (sign[0]&A[31] ? B<<32 : 0) - (sign[1]&B[31] ? A<<32 : 0), modulo 2^64; go DONE.
- DONE: rsp_valid_owner=1 from cycle 6+MUL_LATENCY; other rsp_valid stays 0. Held with rsp_data stable until rsp_ready_owner=1; on that handshake, IDLE next cycle. The earliest next accept is the cycle after the response handshake. rsp_ready of the non-owner is ignored.
- rsp_data retains the last result after handshake until the next FIX.
- busy = (state != IDLE).
- A request held valid while busy waits; no drop, no overflow. The loser of contention keeps waiting and is granted next under RR_EN=1.
- Reset mid-operation: no response is ever produced for the aborted request; the pipeline is flushed, so no stale product is accumulated after reset release.

Test Plan:
1. MUL_LATENCY=1, port 0 A=0xFFFFFFFF B=0xFFFFFFFF sign=00, rsp_ready_0=1 -> rsp_valid_0 first high in cycle 7, rsp_data=0xFFFFFFFE00000001, rsp_valid_1 stays 0.
2. Signed: A=0xFFFFFFFF B=0xFFFFFFFF sign=11 -> 0x0000000000000001; A=0x80000000 B=0x00000002 sign=01 -> 0xFFFFFFFF00000000; A=0x80000000 B=0x80000000 sign=11 -> 0x4000000000000000.
3. After reset, both ports continuously valid, RR_EN=1 -> grant order 0,1,0,1; each result routed only to its owner; with RR_EN=0 -> port 0 every time while it stays valid, port 1 served only once port 0 drops req_valid_0.
4. Backpressure: rsp_ready_0=0 for 10 cycles -> rsp_valid_0 and rsp_data stable; req_ready_0/1=0 and busy=1 throughout; after handshake, next request accepted one cycle later.
5. Assert reset during ISSUE idx 2 -> all outputs 0 immediately; release, issue 0x00010000 x 0x00010000 unsigned -> 0x0000000100000000 with no spurious rsp_valid beforehand.
6. MUL_LATENCY=3, A=0x12345678 B=0x9ABCDEF0 unsigned -> rsp_valid in cycle 9, rsp_data=0x0B00EA4E242D2080.
